serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer: time-shares one full-adder cell across all WIDTH bit positions, LSB first, one bit per clock.
- Low-area alternative to the 64-bit ripple-carry adder; results are bit-exact with it.
- Sits between a requester (start/operands) and the consumer of sum/cout. Owns operand shift registers, carry flop, bit counter and the control FSM.

---
 rtl/serial_add_if.sv | 26 ++
 rtl/serial_add_ctrl.sv | 107 ++++++++++
 tb/tb_serial_add_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_if.sv
// serial_add_if: request/result bundle for the bit-serial adder.
// The master drives operands and control; the slave returns status and result.
interface serial_add_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, abort, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, abort, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer, one full-adder cell, LSB first.
// Takes WIDTH RUN cycles plus one DONE cycle per add.
module serial_add_ctrl #(
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        rst_n,
  serial_add_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic s_bit;
  logic c_nxt;
  logic last;
  logic run;
  logic kill;
  logic step;
  logic accept;

  assign s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nxt  = (a_sr[0] & b_sr[0])
                | (a_sr[0] & carry)
                | (b_sr[0] & carry);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign run    = (state == RUN);
  assign kill   = run & bus.abort;
  assign step   = run & ~bus.abort;
  assign accept = bus.start & (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        kill: begin
          state  <= IDLE;
          cnt    <= '0;
          carry  <= 1'b0;
          busy_q <= 1'b0;
        end
        step: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          carry  <= c_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            // carry holds the carry into the MSB here
            state  <= DONE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= {s_bit, sum_sr[WIDTH-1:1]};
            cout_q <= c_nxt;
            ovf_q  <= carry ^ c_nxt;
          end
        end
        accept: begin
          state  <= RUN;
          a_sr   <= bus.a;
          b_sr   <= bus.b;
          carry  <= bus.cin;
          cnt    <= '0;
          busy_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the bit-serial adder.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_add_ctrl;

  localparam int W = 64;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_add(
    input  logic [W-1:0] ia,
    input  logic [W-1:0] ib,
    input  logic         ic,
    output logic [W-1:0] s,
    output logic         c,
    output logic         o,
    output int           lat,
    output int           bc
  );
    bus.a = ia;
    bus.b = ib;
    bus.cin = ic;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    bc = 0;
    for (int k = 1; k <= 200; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) bc++;
      @(negedge clk);
    end
    s = bus.sum;
    c = bus.cout;
    o = bus.ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.busy, bus.done, bus.cout, bus.ovf});
    end
    n_cmp++;
    if (bus.sum !== '0) begin
      n_bad++;
      $display("FAIL reset_sum: got %h want 0", bus.sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] s;
    logic c, o;
    int lat, bc;
    do_add(64'h5, 64'h3, 1'b1, s, c, o, lat, bc);
    n_cmp++;
    if (s !== 64'h9) begin
      n_bad++;
      $display("FAIL basic_sum: got %h want 9", s);
    end
    n_cmp++;
    if ({c, o} !== 2'b00) begin
      n_bad++;
      $display("FAIL basic_cout_ovf: got %b want 00", {c, o});
    end
    n_cmp++;
    if (lat !== 65) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d want 65", lat);
    end
    n_cmp++;
    if (bc !== 64) begin
      n_bad++;
      $display("FAIL basic_busy_cycles: got %0d want 64", bc);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: got %b want 0", bus.done);
    end
  endtask

  task automatic test_vec(
    input string        nm,
    input logic [W-1:0] ia,
    input logic [W-1:0] ib,
    input logic         ic,
    input logic [W-1:0] es,
    input logic         ec,
    input logic         eo
  );
    logic [W-1:0] s;
    logic c, o;
    int lat, bc;
    do_add(ia, ib, ic, s, c, o, lat, bc);
    n_cmp++;
    if ({c, o, s} !== {ec, eo, es} || lat !== 65) begin
      n_bad++;
      $display("FAIL %s: got c=%b o=%b s=%h lat=%0d want c=%b o=%b s=%h lat=65",
               nm, c, o, s, lat, ec, eo, es);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    bus.a = 64'h1234;
    bus.b = 64'h1111;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == 10) begin
        bus.a = 64'hFFFF_0000_FFFF_0000;
        bus.b = 64'h0F0F_0F0F_0F0F_0F0F;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_cmp++;
    if (bus.sum !== 64'h2345 || lat !== 65) begin
      n_bad++;
      $display("FAIL ignore_start: got s=%h lat=%0d want s=2345 lat=65",
               bus.sum, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s;
    logic c, o;
    int lat, bc;
    logic pre_busy;
    bus.a = 64'h10;
    bus.b = 64'h20;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    pre_busy = 1'b0;
    lat = 0;
    @(negedge clk);
    for (int k = 1; k <= 200; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      pre_busy = bus.busy;
      @(negedge clk);
    end
    n_cmp++;
    if (bus.sum !== 64'h30 || lat !== 65) begin
      n_bad++;
      $display("FAIL b2b_first: got s=%h lat=%0d want s=30 lat=65",
               bus.sum, lat);
    end
    n_cmp++;
    if ({pre_busy, bus.busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_busy_gap: got %b want 10", {pre_busy, bus.busy});
    end
    do_add(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b1, s, c, o, lat, bc);
    n_cmp++;
    if ({c, o, s} !== {2'b10, 64'h11} || lat !== 65 || bc !== 64) begin
      n_bad++;
      $display("FAIL b2b_second: got c=%b o=%b s=%h lat=%0d bc=%0d want c=1 o=0 s=11 lat=65 bc=64",
               c, o, s, lat, bc);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [W-1:0] s;
    logic c, o;
    int lat, bc;
    int dones;
    do_add(64'h5, 64'h3, 1'b1, s, c, o, lat, bc);
    @(negedge clk);
    bus.a = 64'd100;
    bus.b = 64'd200;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got %b want 0", bus.busy);
    end
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    n_cmp++;
    if (dones !== 0 || bus.sum !== 64'h9) begin
      n_bad++;
      $display("FAIL abort_hold: got dones=%0d s=%h want dones=0 s=9",
               dones, bus.sum);
    end
    do_add(64'd100, 64'd200, 1'b0, s, c, o, lat, bc);
    n_cmp++;
    if (s !== 64'd300 || lat !== 65) begin
      n_bad++;
      $display("FAIL abort_restart: got s=%h lat=%0d want s=12c lat=65", s, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int dones;
    bus.a = 64'h1;
    bus.b = 64'h2;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #0.5;
    n_cmp++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf} !== 4'b0 || bus.sum !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_run: got busy=%b done=%b c=%b o=%b s=%h want all 0",
               bus.busy, bus.done, bus.cout, bus.ovf, bus.sum);
    end
    #0.5;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d active cycles want 0", dones);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, s;
    logic rc, c, o;
    logic [W:0] r;
    logic eo;
    int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(1, 0));
      r = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      eo = (ra[W-1] == rb[W-1]) && (r[W-1] != ra[W-1]);
      do_add(ra, rb, rc, s, c, o, lat, bc);
      n_cmp++;
      if ({c, o, s} !== {r[W], eo, r[W-1:0]} || lat !== 65) begin
        n_bad++;
        $display("FAIL random_%0d: a=%h b=%h cin=%b got c=%b o=%b s=%h lat=%0d want c=%b o=%b s=%h",
                 i, ra, rb, rc, c, o, s, lat, r[W], eo, r[W-1:0]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_vec("carry_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
             64'h0, 1'b1, 1'b0);
    test_vec("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    test_vec("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
             64'h0, 1'b1, 1'b1);
    test_vec("cin_only", 64'h0, 64'h0, 1'b1,
             64'h1, 1'b0, 1'b0);
    @(negedge clk);
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
